// File: rtl/corrector_hamming_secded.sv
// Pipelined Hamming SECDED decoder: stage 1 computes syndrome/parity, stage 2 corrects and
// classifies; valid/ready on both sides with saturating corrected/uncorrectable counters.
module corrector_hamming_secded #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned PAR_W  = 3,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W+PAR_W:0] in_code,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_corr,
    output logic                  out_uncorr,
    output logic [PAR_W-1:0]      out_pos,
    input  logic                  clr_cnt,
    output logic [CNT_W-1:0]      cnt_corr,
    output logic [CNT_W-1:0]      cnt_uncorr
);

    localparam int unsigned CW = DATA_W + PAR_W + 1;

    if ((2 ** PAR_W) < CW) begin : g_bad_params
        $error("corrector_hamming_secded: PAR_W too small for DATA_W");
    end

    // Hamming position of data bit idx: the idx-th non-power-of-two position.
    function automatic int unsigned data_pos(input int unsigned idx);
        int unsigned n;
        data_pos = 0;
        n        = 0;
        for (int unsigned p = 1; p < CW; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == idx) data_pos = p;
                n++;
            end
        end
    endfunction

    logic              s1_valid_q, s1_valid_d;
    logic [CW-1:0]     s1_code_q,  s1_code_d;
    logic [PAR_W-1:0]  s1_syn_q,   s1_syn_d;
    logic              s1_par_q,   s1_par_d;
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_data_q,  s2_data_d;
    logic              s2_corr_q,  s2_corr_d;
    logic              s2_uncorr_q, s2_uncorr_d;
    logic [PAR_W-1:0]  s2_pos_q,   s2_pos_d;
    logic [CNT_W-1:0]  cnt_corr_q, cnt_corr_d;
    logic [CNT_W-1:0]  cnt_uncorr_q, cnt_uncorr_d;

    logic              s2_load;
    logic              in_xfer;
    logic              out_xfer;
    logic              fixable;
    logic [CW-1:0]     code_fix;
    logic [CW-1:0]     code_sh;
    logic [DATA_W-1:0] data_fix;
    logic [PAR_W-1:0]  syn_c;

    assign s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
    assign in_ready = ~s1_valid_q | s2_load;
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = s2_valid_q & out_ready;

    // Next-state logic for both pipeline stages and the counters.
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_code_d    = s1_code_q;
        s1_syn_d     = s1_syn_q;
        s1_par_d     = s1_par_q;
        s2_valid_d   = s2_valid_q;
        s2_data_d    = s2_data_q;
        s2_corr_d    = s2_corr_q;
        s2_uncorr_d  = s2_uncorr_q;
        s2_pos_d     = s2_pos_q;
        cnt_corr_d   = cnt_corr_q;
        cnt_uncorr_d = cnt_uncorr_q;
        syn_c        = '0;
        code_sh      = '0;
        data_fix     = '0;

        for (int unsigned i = 1; i < CW; i++) begin
            if (in_code[i]) syn_c = syn_c ^ PAR_W'(i);
        end

        // Odd overall parity with an in-range syndrome is a single error; anything else nonzero is not.
        fixable  = s1_par_q & (32'(s1_syn_q) < CW);
        code_fix = fixable ? (s1_code_q ^ (CW'(1) << s1_syn_q)) : s1_code_q;
        for (int unsigned j = 0; j < DATA_W; j++) begin
            code_sh     = code_fix >> data_pos(j);
            data_fix[j] = code_sh[0];
        end

        if (in_xfer) begin
            s1_valid_d = 1'b1;
            s1_code_d  = in_code;
            s1_syn_d   = syn_c;
            s1_par_d   = ^in_code;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) begin
            s2_valid_d  = 1'b1;
            s2_data_d   = data_fix;
            s2_corr_d   = fixable;
            s2_uncorr_d = s1_par_q ? ~fixable : (s1_syn_q != '0);
            s2_pos_d    = fixable ? s1_syn_q : '0;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end

        if (clr_cnt) begin
            cnt_corr_d   = '0;
            cnt_uncorr_d = '0;
        end else begin
            if (out_xfer && s2_corr_q && !(&cnt_corr_q))
                cnt_corr_d = cnt_corr_q + CNT_W'(1);
            if (out_xfer && s2_uncorr_q && !(&cnt_uncorr_q))
                cnt_uncorr_d = cnt_uncorr_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_code_q    <= '0;
            s1_syn_q     <= '0;
            s1_par_q     <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_data_q    <= '0;
            s2_corr_q    <= 1'b0;
            s2_uncorr_q  <= 1'b0;
            s2_pos_q     <= '0;
            cnt_corr_q   <= '0;
            cnt_uncorr_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_code_q    <= s1_code_d;
            s1_syn_q     <= s1_syn_d;
            s1_par_q     <= s1_par_d;
            s2_valid_q   <= s2_valid_d;
            s2_data_q    <= s2_data_d;
            s2_corr_q    <= s2_corr_d;
            s2_uncorr_q  <= s2_uncorr_d;
            s2_pos_q     <= s2_pos_d;
            cnt_corr_q   <= cnt_corr_d;
            cnt_uncorr_q <= cnt_uncorr_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_data   = s2_data_q;
    assign out_corr   = s2_corr_q;
    assign out_uncorr = s2_uncorr_q;
    assign out_pos    = s2_pos_q;
    assign cnt_corr   = cnt_corr_q;
    assign cnt_uncorr = cnt_uncorr_q;

endmodule

// File: doc/corrector_hamming_secded.md
Name: corrector_hamming_secded

Overview:
- Parametrised, pipelined Hamming SECDED decoder/corrector. Generalises the 7-bit combinational single-error corrector to any data width, and adds an overall-parity bit for double-error detection.
- Sits between the channel/receive path and the data consumer. Uses valid/ready handshakes on both sides, exposes per-word error status, and keeps saturating error counters.

Parameters:
- DATA_W, 4, number of information bits per word.
- PAR_W, 3, number of Hamming parity bits. Elaboration fails unless 2**PAR_W >= DATA_W+PAR_W+1.
- CNT_W, 16, width of each error counter.
- Derived: CW = DATA_W+PAR_W+1 (codeword width, 8 by default).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_valid  input  1  in_code holds a valid codeword.
- in_ready  output  1  block accepts in_code this cycle.
- in_code  input  CW  received codeword; bit 0 is overall parity, bit i (1..CW-1) is Hamming position i.
- out_valid  output  1  out_* fields hold a decoded word.
- out_ready  input  1  consumer accepts the output this cycle.
- out_data  output  DATA_W  corrected information bits.
- out_corr  output  1  a single error was corrected in this word.
- out_uncorr  output  1  uncorrectable error; out_data is raw, uncorrected.
- out_pos  output  PAR_W  corrected bit position (0 = overall parity bit); 0 when out_corr=0.
- clr_cnt  input  1  synchronous clear of both counters.
- cnt_corr  output  CNT_W  count of corrected words, saturating.
- cnt_uncorr  output  CNT_W  count of uncorrectable words, saturating.

Behaviour:
- Codeword layout: Hamming positions that are powers of two (1, 2, 4, …) carry parity. Data bits occupy the remaining positions in ascending order: data[0] is at position 3, then 5, 6, 7, 9, and so on. Bit 0 is even parity over bits CW-1..0.
- Handshakes: a transfer occurs when valid & ready are both high.
  - in_code is sampled only on an input transfer.
  - Output fields hold stable while out_valid=1 and out_ready=0.
- Pipeline has 2 stages; each has a valid flag.
  - Stage 1 registers in_code, syndrome s = XOR of indices i with in_code[i]=1 (i = 1..CW-1), and overall parity p = ^in_code.
  - Stage 2 registers corrected data and status.
- Latency: exactly 2 cycles from input transfer to out_valid when out_ready is held high. Throughput is 1 word per cycle.
- Advance rules:
  - Stage 2 loads when stage 1 is valid and (stage 2 empty or out_ready).
  - Stage 1 loads on an input transfer.
  - in_ready = ~s1_valid | s2_load.
  - Full backpressure holds both stages; no words are lost or duplicated.
- Decode table in stage 2:
  - s=0, p=0: clean. corr=0, uncorr=0.
  - p=1, s<CW: single error at position s. Flip bit s, corr=1, pos=s; s=0 means only the parity bit is flipped and data is unchanged.
  - p=1, s>=CW: uncorrectable (unused position). uncorr=1.
  - p=0, s!=0: double error. uncorr=1, data extracted without correction.
  - corr and uncorr are never both 1.
- Counters:
  - Increment on an output transfer with out_corr (respectively out_uncorr) set.
  - Saturate at all-ones; no wrap.
  - clr_cnt takes priority over a same-cycle increment; the result is 0.
- Reset (asynchronous, any time): stage valid flags, out_valid, all out_* fields and both counters go to 0. in_ready is 1 from the first cycle after deassertion. Words in flight are discarded.

Test Plan (defaults; data 4'hB encodes to 8'hAA):
- Clean path: in_code=8'hAA, out_ready=1 -> 2 cycles later out_valid=1, out_data=4'hB, corr=0, uncorr=0, pos=0; counters stay 0.
- Single error: 8'h8A (bit 5 flipped) -> out_data=4'hB, out_corr=1, out_pos=5, cnt_corr=1. 8'hAB (bit 0 flipped) -> out_data=4'hB, out_corr=1, out_pos=0, cnt_corr=2.
- Double error: 8'h82 (bits 3 and 5 flipped) -> out_uncorr=1, out_corr=0, out_data=4'h8, cnt_uncorr=1.
- Backpressure: stream 8'hAA, 8'h8A, 8'h82, 8'hAB back-to-back; hold out_ready=0 for 5 cycles -> in_ready drops after 2 accepts, outputs stay stable, then all 4 words emerge in order with no loss.
- Counter edges: with CNT_W=2, send 4 single-error words -> cnt_corr saturates at 3. Assert clr_cnt on the cycle of a corrected-word transfer -> cnt_corr=0.
- Reset mid-stream: assert rst_n=0 with both stages full -> out_valid=0 and counters 0 immediately. After release, 8'hAA decodes normally with 2-cycle latency.
